counter_mem_responder: RTL and testbench

- Memory-side responder for the counter's memory request interface (mem_address, mem_read, mem_write, mem_data_write, mem_data_read).
- Stores counter state words in a DEPTH x DATA_W array and returns read data after a fixed, parameterised latency.
- Clears its contents after reset and signals readiness to the initiator. Sits beside counter_memory in the stopwatch top.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/mem_rd_pipe.sv | 46 ++++
 rtl/counter_mem_responder.sv | 85 ++++++++
 tb/tb_counter_mem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter memory path.
// Used by counter_memory and counter_mem_responder.
package stopwatch_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 4;
    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency return pipe carrying {valid, err, data} per stage.
// Data in each stage only advances with a valid beat, so the tail holds.
module mem_rd_pipe
    import stopwatch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic              vld [LATENCY];
    logic              err [LATENCY];
    logic [DATA_W-1:0] dat [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld[i] <= 1'b0;
                err[i] <= 1'b0;
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_vld;
            err[0] <= in_err;
            if (in_vld) dat[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                err[i] <= err[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_vld  = vld[LATENCY-1];
    assign out_err  = err[LATENCY-1];
    assign out_data = dat[LATENCY-1];

endmodule

// File: rtl/counter_mem_responder.sv
// Memory-side responder for the counter request bus: clears itself
// after reset, then serves reads/writes with a fixed read latency.
module counter_mem_responder
    import stopwatch_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_write,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_data_read,
    output logic              mem_rvalid,
    output logic              mem_err
);

    localparam logic [0:0] S_INIT  = INIT;
    localparam logic [0:0] S_SERVE = SERVE;

    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              oor;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_word;

    assign mem_ready = (state == S_SERVE);
    assign oor       = ({1'b0, mem_address} >= DEPTH_V);
    assign rd_acc    = mem_ready & mem_read;
    assign wr_acc    = mem_ready & mem_write;

    // Write-first: a same-cycle write is what the read returns.
    always_comb begin
        rd_word = '0;
        if (!oor) begin
            rd_word = mem_write ? mem_data_write : mem[mem_address];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_INIT;
            ptr   <= '0;
        end else begin
            if (state == S_INIT) begin
                ptr <= ptr + 1'b1;
                if (ptr == LAST) state <= S_SERVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[ptr] <= '0;
        end else if (wr_acc && !oor) begin
            mem[mem_address] <= mem_data_write;
        end
    end

    mem_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_acc),
        .in_err   ((rd_acc | wr_acc) & oor),
        .in_data  (rd_word),
        .out_vld  (mem_rvalid),
        .out_err  (mem_err),
        .out_data (mem_data_read)
    );

endmodule

// File: tb/tb_counter_mem_responder.sv
// Bench for counter_mem_responder: a default instance and a DEPTH=10
// instance driven from one vector table, checked by a timed scoreboard.
module tb_counter_mem_responder;

    localparam int LAT     = 2;
    localparam int DEPTH_B = 10;

    typedef struct {
        int          due;
        logic        rv;
        logic        err;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_data_write;
    logic        b_en;
    logic        b_read;
    logic        b_write;

    logic        rdy_a, rv_a, er_a;
    logic [15:0] dr_a;
    logic        rdy_b, rv_b, er_b;
    logic [15:0] dr_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   run = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] last_a;
    logic [15:0] last_b;
    vec_t tbl [21];

    assign b_read  = mem_read & b_en;
    assign b_write = mem_write & b_en;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counter_mem_responder u_a (
        .clk            (clk),
        .rst            (rst),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_data_write (mem_data_write),
        .mem_ready      (rdy_a),
        .mem_data_read  (dr_a),
        .mem_rvalid     (rv_a),
        .mem_err        (er_a)
    );

    counter_mem_responder #(.DEPTH(DEPTH_B)) u_b (
        .clk            (clk),
        .rst            (rst),
        .mem_address    (mem_address),
        .mem_read       (b_read),
        .mem_write      (b_write),
        .mem_data_write (mem_data_write),
        .mem_ready      (rdy_b),
        .mem_data_read  (dr_b),
        .mem_rvalid     (rv_b),
        .mem_err        (er_b)
    );

    task automatic cmp(input string nm, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", nm, cyc, got, want);
        end
    endtask

    task automatic chk(input int u, input logic rv, input logic er,
                       input logic [15:0] d);
        exp_t e;
        bit   have;
        string p;
        have = 0;
        e = '{0, 1'b0, 1'b0, 16'h0};
        p = (u == 0) ? "a." : "b.";
        if (u == 0) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                have = 1;
            end
        end else begin
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                have = 1;
            end
        end
        if (have) begin
            cmp({p, "rvalid"}, 16'(rv), 16'(e.rv));
            cmp({p, "err"}, 16'(er), 16'(e.err));
            if (e.rv) begin
                cmp({p, "rdata"}, d, e.data);
                if (u == 0) last_a = e.data;
                else last_b = e.data;
            end
        end else begin
            cmp({p, "idle_rvalid"}, 16'(rv), 16'h0);
            cmp({p, "idle_err"}, 16'(er), 16'h0);
        end
        if (!have || !e.rv) begin
            cmp({p, "hold"}, d, (u == 0) ? last_a : last_b);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk(0, rv_a, er_a, dr_a);
            chk(1, rv_b, er_b, dr_b);
        end
    end

    task automatic drive(input vec_t v);
        logic oob;
        oob = (v.addr >= 4'(DEPTH_B));
        mem_read       = v.rd;
        mem_write      = v.wr;
        mem_address    = v.addr;
        mem_data_write = v.wdata;
        if (v.rd) begin
            qa.push_back('{cyc + LAT, 1'b1, 1'b0, v.exp});
            qb.push_back('{cyc + LAT, 1'b1, oob, oob ? 16'h0 : v.exp});
        end else if (v.wr && oob) begin
            qb.push_back('{cyc + LAT, 1'b0, 1'b1, 16'h0});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 4'd5,  16'hBEEF, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 4'd5,  16'h0000, 16'hBEEF};
        tbl[2]  = '{1'b1, 1'b1, 4'd7,  16'h1234, 16'h1234};
        tbl[3]  = '{1'b0, 1'b1, 4'd2,  16'h0AAA, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 4'd2,  16'h0000, 16'h0AAA};
        tbl[5]  = '{1'b0, 1'b1, 4'd2,  16'h0BBB, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 4'd2,  16'h0000, 16'h0BBB};
        tbl[7]  = '{1'b0, 1'b1, 4'd0,  16'h0001, 16'h0000};
        tbl[8]  = '{1'b0, 1'b1, 4'd1,  16'h0002, 16'h0000};
        tbl[9]  = '{1'b0, 1'b1, 4'd2,  16'h0003, 16'h0000};
        tbl[10] = '{1'b0, 1'b1, 4'd3,  16'h0004, 16'h0000};
        tbl[11] = '{1'b1, 1'b0, 4'd0,  16'h0000, 16'h0001};
        tbl[12] = '{1'b1, 1'b0, 4'd1,  16'h0000, 16'h0002};
        tbl[13] = '{1'b1, 1'b0, 4'd2,  16'h0000, 16'h0003};
        tbl[14] = '{1'b1, 1'b0, 4'd3,  16'h0000, 16'h0004};
        tbl[15] = '{1'b1, 1'b0, 4'd12, 16'h0000, 16'h0000};
        tbl[16] = '{1'b0, 1'b1, 4'd12, 16'h5555, 16'h0000};
        tbl[17] = '{1'b1, 1'b0, 4'd12, 16'h0000, 16'h5555};
        tbl[18] = '{1'b1, 1'b0, 4'd15, 16'h0000, 16'h0000};
        tbl[19] = '{1'b1, 1'b0, 4'd9,  16'h0000, 16'h0000};
        tbl[20] = '{1'b1, 1'b0, 4'd10, 16'h0000, 16'h0000};

        rst            = 1'b0;
        mem_address    = 4'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_data_write = 16'h0;
        b_en           = 1'b0;
        last_a         = 16'h0;
        last_b         = 16'h0;

        repeat (2) @(negedge clk);
        run = 1;
        @(negedge clk);
        cmp("a.reset_ready", 16'(rdy_a), 16'h0);
        cmp("b.reset_ready", 16'(rdy_b), 16'h0);

        // Reads held through INIT are ignored; only post-INIT ones return.
        mem_read    = 1'b1;
        mem_address = 4'd3;
        rst         = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            cmp("a.init_ready", 16'(rdy_a), 16'(k >= 16));
            cmp("b.init_ready", 16'(rdy_b), 16'(k >= DEPTH_B));
            if (k >= 16 && k < 18) begin
                qa.push_back('{cyc + LAT, 1'b1, 1'b0, 16'h0000});
            end
        end
        idle();
        b_en = 1'b1;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) drive(tbl[i]);
        idle();
        repeat (4) @(negedge clk);

        // Two reads in flight when reset hits: neither may return.
        mem_read    = 1'b1;
        mem_address = 4'd5;
        @(negedge clk);
        mem_address = 4'd7;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        last_a = 16'h0;
        last_b = 16'h0;
        repeat (3) begin
            @(negedge clk);
            cmp("a.rst_ready", 16'(rdy_a), 16'h0);
            cmp("a.rst_rdata", dr_a, 16'h0);
            cmp("b.rst_rdata", dr_b, 16'h0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            cmp("a.reinit_ready", 16'(rdy_a), 16'(k >= 16));
            cmp("b.reinit_ready", 16'(rdy_b), 16'(k >= DEPTH_B));
        end
        drive('{1'b1, 1'b0, 4'd5, 16'h0, 16'h0000});
        drive('{1'b1, 1'b0, 4'd7, 16'h0, 16'h0000});
        drive('{1'b1, 1'b0, 4'd0, 16'h0, 16'h0000});
        idle();
        repeat (5) @(negedge clk);

        cmp("a.drain", 16'(qa.size()), 16'h0);
        cmp("b.drain", 16'(qb.size()), 16'h0);
        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
